// File: rtl/refresh_executor_if.sv
// Refresh handshake and command-port bundle between refresh timer, executor and scheduler.
// master = executor side; refresh_count/drain_max exist only with REFRESH_STATS_EN.
interface refresh_executor_if;
    logic       refresh_req;
    logic       refresh_start;
    logic       refresh_ack;
    logic       banks_idle;
    logic       any_bank_open;
    logic       block_new;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd;
    logic       busy;
`ifdef REFRESH_STATS_EN
    logic [15:0] refresh_count;
    logic [15:0] drain_max;
`endif

    modport master (
        input  refresh_req, banks_idle, any_bank_open, cmd_ready,
        output refresh_start, refresh_ack, block_new, cmd_valid, cmd, busy
`ifdef REFRESH_STATS_EN
        , output refresh_count, drain_max
`endif
    );

    modport slave (
        output refresh_req, banks_idle, any_bank_open, cmd_ready,
        input  refresh_start, refresh_ack, block_new, cmd_valid, cmd, busy
`ifdef REFRESH_STATS_EN
        , input refresh_count, drain_max
`endif
    );
endinterface

// File: rtl/refresh_executor.sv
// DRAM refresh responder: drain traffic, PRECHARGE_ALL if needed, REFRESH_BURST refreshes, ack (stats: REFRESH_STATS_EN).
// Start pulse one cycle after request; commands held until cmd_ready; all outputs from registers/state only.
module refresh_executor #(
    parameter int T_RP          = 3,
    parameter int T_RFC         = 44,
    parameter int REFRESH_BURST = 1
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    refresh_executor_if.master bus
);
    localparam int T_MAX = (T_RP > T_RFC) ? T_RP : T_RFC;
    localparam int TW    = $clog2(T_MAX + 1);

    localparam logic [TW-1:0] RP_LOAD  = TW'(T_RP - 1);
    localparam logic [TW-1:0] RFC_LOAD = TW'(T_RFC - 1);
    localparam logic [TW-1:0] T_ONE    = TW'(1);
    localparam logic [3:0]    BURST_N  = 4'(REFRESH_BURST);

    localparam logic [2:0] CMD_NOP = 3'b000;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_REF = 3'b001;

    typedef enum logic [2:0] {
        S_IDLE, S_DRAIN, S_PRE, S_WAIT_RP, S_REF, S_WAIT_RFC, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    burst_q, burst_d;
    logic          rearm_q, rearm_d;
    logic          start_q, start_d;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            burst_q <= '0;
            rearm_q <= 1'b1;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            burst_q <= burst_d;
            rearm_q <= rearm_d;
            start_q <= start_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        burst_d = burst_q;
        rearm_d = rearm_q;
        start_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!bus.refresh_req) begin
                    rearm_d = 1'b1;
                end else if (rearm_q) begin
                    state_d = S_DRAIN;
                    start_d = 1'b1;
                    burst_d = '0;
                end
            end
            S_DRAIN: begin
                if (bus.banks_idle) begin
                    state_d = bus.any_bank_open ? S_PRE : S_REF;
                end
            end
            S_PRE: begin
                // The handshake cycle is the first tRP cycle, so WAIT_RP lasts T_RP-1 cycles.
                if (bus.cmd_ready) begin
                    if (T_RP == 1) begin
                        state_d = S_REF;
                    end else begin
                        state_d = S_WAIT_RP;
                        timer_d = RP_LOAD;
                    end
                end
            end
            S_WAIT_RP: begin
                timer_d = timer_q - T_ONE;
                if (timer_q <= T_ONE) begin
                    state_d = S_REF;
                    timer_d = '0;
                end
            end
            S_REF: begin
                if (bus.cmd_ready) begin
                    burst_d = burst_q + 4'd1;
                    state_d = S_WAIT_RFC;
                    timer_d = RFC_LOAD;
                end
            end
            S_WAIT_RFC: begin
                if (timer_q == '0) begin
                    state_d = (burst_q < BURST_N) ? S_REF : S_DONE;
                end else begin
                    timer_d = timer_q - T_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                rearm_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.refresh_start = start_q;
    assign bus.refresh_ack   = (state_q == S_DONE);
    assign bus.block_new     = (state_q != S_IDLE);
    assign bus.busy          = (state_q != S_IDLE);
    assign bus.cmd_valid     = (state_q == S_PRE) || (state_q == S_REF);
    assign bus.cmd           = (state_q == S_PRE) ? CMD_PRE :
                               (state_q == S_REF) ? CMD_REF : CMD_NOP;

`ifdef REFRESH_STATS_EN
    logic [15:0] count_q, count_d;
    logic [15:0] dmax_q, dmax_d;
    logic [15:0] dcnt_q, dcnt_d;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            count_q <= '0;
            dmax_q  <= '0;
            dcnt_q  <= '0;
        end else begin
            count_q <= count_d;
            dmax_q  <= dmax_d;
            dcnt_q  <= dcnt_d;
        end
    end

    // dcnt_d is the residency including the current DRAIN cycle.
    always_comb begin
        count_d = count_q;
        dmax_d  = dmax_q;
        dcnt_d  = '0;
        if (state_q == S_DONE && count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
        end
        if (state_q == S_DRAIN) begin
            dcnt_d = (dcnt_q == 16'hFFFF) ? dcnt_q : dcnt_q + 16'd1;
            if (dcnt_d > dmax_q) begin
                dmax_d = dcnt_d;
            end
        end
    end

    assign bus.refresh_count = count_q;
    assign bus.drain_max     = dmax_q;
`endif
endmodule

// File: tb/tb_refresh_executor.sv
// Bench for refresh_executor: directed timing table, rearm/reset sequences, random run vs a queue-based model.
module tb_refresh_executor;
    localparam int T_RP  = 3;
    localparam int T_RFC = 8;
    localparam int BURST = 2;
    localparam logic [2:0] C_NOP = 3'b000;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_REF = 3'b001;

    logic sys_clk = 1'b0;
    logic sys_rst_n;
    refresh_executor_if rif();

    refresh_executor #(.T_RP(T_RP), .T_RFC(T_RFC), .REFRESH_BURST(BURST)) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .bus      (rif)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int t0 = 0;

    task automatic chk(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    function automatic int qget(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    // Reference model: a command queue plus earliest-issue times derived from tRP/tRFC.
    bit         mon_en = 1'b0;
    bit         m_seq = 1'b0, m_rearm = 1'b1, m_drained = 1'b0;
    int         m_start_c = 0, m_ack_c = -1, m_next = 0;
    logic [2:0] m_q[$];

    int ev_start[$], ev_pre[$], ev_ref[$], ev_refhs[$], ev_ack[$];
    int ev_blk_low = -1;
    bit prev_vld = 1'b0, prev_hs = 1'b0;

    always @(negedge sys_clk) begin
        logic [7:0] got, want;
        bit         e_vld;
        logic [2:0] e_cmd, k;
        if (mon_en) begin
            e_vld = m_seq && m_drained && (m_q.size() > 0) && (cyc >= m_next);
            e_cmd = e_vld ? m_q[0] : C_NOP;
            want  = {m_seq && cyc == m_start_c, m_seq && cyc == m_ack_c, m_seq, m_seq, e_vld, e_cmd};
            got   = {rif.refresh_start, rif.refresh_ack, rif.block_new, rif.busy, rif.cmd_valid, rif.cmd};
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL model cyc %0d {start,ack,blk,busy,vld,cmd}: got %b expected %b", cyc, got, want);
            end

            if (rif.refresh_start) ev_start.push_back(cyc - t0);
            if (rif.cmd_valid && (!prev_vld || prev_hs)) begin
                if (rif.cmd == C_PRE) ev_pre.push_back(cyc - t0);
                else if (rif.cmd == C_REF) ev_ref.push_back(cyc - t0);
            end
            if (rif.cmd_valid && rif.cmd_ready && rif.cmd == C_REF) ev_refhs.push_back(cyc - t0);
            if (rif.refresh_ack) ev_ack.push_back(cyc - t0);
            if (ev_ack.size() > 0 && !rif.block_new && ev_blk_low < 0) ev_blk_low = cyc - t0;
            prev_vld = rif.cmd_valid;
            prev_hs  = rif.cmd_valid && rif.cmd_ready;

            if (!sys_rst_n) begin
                m_seq   = 1'b0;
                m_rearm = 1'b1;
                m_q.delete();
            end else if (!m_seq) begin
                if (!rif.refresh_req) begin
                    m_rearm = 1'b1;
                end else if (m_rearm) begin
                    m_seq     = 1'b1;
                    m_start_c = cyc + 1;
                    m_drained = 1'b0;
                    m_ack_c   = -1;
                end
            end else if (cyc == m_ack_c) begin
                m_seq   = 1'b0;
                m_rearm = 1'b0;
            end else if (!m_drained) begin
                if (rif.banks_idle) begin
                    m_drained = 1'b1;
                    m_next    = cyc + 1;
                    m_q.delete();
                    if (rif.any_bank_open) m_q.push_back(C_PRE);
                    repeat (BURST) m_q.push_back(C_REF);
                end
            end else if (e_vld && rif.cmd_ready) begin
                k      = m_q.pop_front();
                m_next = cyc + ((k == C_PRE) ? T_RP : T_RFC + 1);
                if (m_q.size() == 0) m_ack_c = m_next;
            end
        end
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic clear_log();
        ev_start.delete();
        ev_pre.delete();
        ev_ref.delete();
        ev_refhs.delete();
        ev_ack.delete();
        ev_blk_low = -1;
    endtask

    task automatic do_reset();
        sys_rst_n         = 1'b0;
        rif.refresh_req   = 1'b0;
        rif.banks_idle    = 1'b1;
        rif.any_bank_open = 1'b0;
        rif.cmd_ready     = 1'b1;
        step();
        step();
        sys_rst_n = 1'b1;
        t0 = cyc;
        clear_log();
    endtask

    // Cycle numbers are relative to the first cycle after reset release; request rises at 10.
    typedef struct {
        bit open;
        int dwait;
        int stall_at;
        int stall_len;
        int e_start, e_pre, e_ref1, e_ref2, e_ref2hs, e_ack, e_blk;
    } vec_t;

    vec_t vt[5];

    initial begin
        vt[0] = '{1, 0, -1, 0, 11, 12, 15, 24, 24, 33, 34};
        vt[1] = '{0, 0, -1, 0, 11, -1, 12, 21, 21, 30, 31};
        vt[2] = '{1, 20, -1, 0, 11, 32, 35, 44, 44, 53, 54};
        vt[3] = '{1, 0, 24, 4, 11, 12, 15, 24, 28, 37, 38};
        vt[4] = '{0, 5, -1, 0, 11, -1, 17, 26, 26, 35, 36};

        sys_rst_n         = 1'b0;
        rif.refresh_req   = 1'b0;
        rif.banks_idle    = 1'b1;
        rif.any_bank_open = 1'b0;
        rif.cmd_ready     = 1'b1;
        step();
        step();
        mon_en = 1'b1;
        @(negedge sys_clk);
        chk("reset outputs", int'({rif.refresh_start, rif.refresh_ack, rif.block_new, rif.busy,
                                   rif.cmd_valid, rif.cmd}), 0);
        step();

        for (int i = 0; i < 5; i++) begin
            do_reset();
            for (int r = 0; r < 60; r++) begin
                rif.refresh_req   = (r >= 10) && (ev_ack.size() == 0);
                rif.banks_idle    = !(r >= 11 && r < 11 + vt[i].dwait);
                rif.any_bank_open = vt[i].open;
                rif.cmd_ready     = !(vt[i].stall_at >= 0 && r >= vt[i].stall_at &&
                                      r < vt[i].stall_at + vt[i].stall_len);
                step();
            end
            chk($sformatf("v%0d start", i), qget(ev_start, 0), vt[i].e_start);
            chk($sformatf("v%0d precharge", i), qget(ev_pre, 0), vt[i].e_pre);
            chk($sformatf("v%0d refresh1", i), qget(ev_ref, 0), vt[i].e_ref1);
            chk($sformatf("v%0d refresh2", i), qget(ev_ref, 1), vt[i].e_ref2);
            chk($sformatf("v%0d refresh2 handshake", i), qget(ev_refhs, 1), vt[i].e_ref2hs);
            chk($sformatf("v%0d ack", i), qget(ev_ack, 0), vt[i].e_ack);
            chk($sformatf("v%0d block_new low", i), ev_blk_low, vt[i].e_blk);
            chk($sformatf("v%0d start count", i), ev_start.size(), 1);
            chk($sformatf("v%0d ack count", i), ev_ack.size(), 1);
            chk($sformatf("v%0d refresh count", i), ev_ref.size(), BURST);
`ifdef REFRESH_STATS_EN
            chk($sformatf("v%0d refresh_count", i), int'(rif.refresh_count), 1);
            chk($sformatf("v%0d drain_max", i), int'(rif.drain_max), vt[i].dwait + 1);
`endif
        end

        // Request held 5 cycles past ack must not retrigger; drop then reassert does.
        do_reset();
        for (int r = 0; r < 60; r++) begin
            rif.refresh_req   = (r >= 10 && r <= 38) || (r >= 42);
            rif.any_bank_open = 1'b1;
            step();
        end
        chk("rearm first start", qget(ev_start, 0), 11);
        chk("rearm first ack", qget(ev_ack, 0), 33);
        chk("rearm second start", qget(ev_start, 1), 43);
        chk("rearm start count", ev_start.size(), 2);

        // Second sequence is now in WAIT_RFC (refresh2 due at 56, then waiting); reset abandons it.
`ifdef REFRESH_STATS_EN
        chk("stats count before reset", int'(rif.refresh_count), 1);
`endif
        sys_rst_n       = 1'b0;
        rif.refresh_req = 1'b0;
        step();
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        chk("reset mid busy", rif.busy, 0);
        chk("reset mid block_new", rif.block_new, 0);
        chk("reset mid cmd_valid", rif.cmd_valid, 0);
        chk("reset mid ack", rif.refresh_ack, 0);
`ifdef REFRESH_STATS_EN
        chk("reset mid refresh_count", int'(rif.refresh_count), 0);
        chk("reset mid drain_max", int'(rif.drain_max), 0);
`endif
        for (int r = 0; r < 30; r++) step();
        chk("reset mid no late ack", ev_ack.size(), 1);
        chk("reset mid no restart", ev_start.size(), 2);

        // Random traffic with occasional resets, checked cycle by cycle against the model.
        do_reset();
        for (int r = 0; r < 4000; r++) begin
            if ($urandom_range(0, 9) == 0) rif.refresh_req = ~rif.refresh_req;
            rif.banks_idle    = ($urandom_range(0, 3) != 0);
            rif.any_bank_open = 1'($urandom_range(0, 1));
            rif.cmd_ready     = ($urandom_range(0, 2) != 0);
            sys_rst_n         = ($urandom_range(0, 599) != 0);
            step();
        end
        chk("random acks observed", int'(ev_ack.size() > 5), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
